aes_dec_round_ctrl: RTL and testbench
=====================================

// Module: aes_dec_round_ctrl
// PURPOSE
//  Iterative AES-128 inverse-cipher controller. Wraps one decrypt round datapath.
//  Accepts a ciphertext block, reads round keys from a key store by index, and applies
//  the initial AddRoundKey(k[NR]). It then drives the round datapath NR times with keys
//  NR-1..0, asserting last_round on key 0, and returns the plaintext via valid/ready.
// PARAMETERS
//  NR           10   number of cipher rounds; key store holds keys 0..NR
//  DEC_LATENCY  1    clk edges from dec_data/dec_round_key stable to dec_decrypted valid (>=0)
// PORTS
//  clk            in   1    clock, rising edge
//  n_rst          in   1    reset, asynchronous, active-high
//  in_valid       in   1    ciphertext offered
//  in_ready       out  1    block can accept ciphertext
//  ciphertext     in   128  input block
//  key_addr       out  4    round-key index to key store
//  key_data       in   128  round key for key_addr, combinational read, same cycle
//  dec_data       out  128  state to round datapath
//  dec_round_key  out  128  key to round datapath (= key_data)
//  dec_last_round out  1    final round: datapath skips InvMixColumns
//  dec_decrypted  in   128  round datapath result
//  out_valid      out  1    plaintext valid
//  out_ready      in   1    consumer accepts plaintext
//  plaintext      out  128  result block
//  busy           out  1    high in every state except IDLE
// BEHAVIOUR
//  Reset (async, n_rst=1): fsm=IDLE, state_reg=0, round=0, lat_cnt=0, plaintext=0.
//   Outputs: in_ready=1, out_valid=0, busy=0, dec_last_round=0, key_addr=0.
//  Reset asserted mid-operation aborts the block; no output is produced for it.
//  FSM IDLE -> WHITEN -> RUN -> DONE -> IDLE:
//   IDLE:   in_ready=1; on in_valid&in_ready, capture ciphertext into state_reg; go to WHITEN.
//   WHITEN: key_addr=NR; state_reg<=state_reg^key_data; round<=NR-1; lat_cnt<=0; go to RUN.
//   RUN:    key_addr=round, dec_data=state_reg, dec_round_key=key_data,
//           dec_last_round=(round==0). Drives are stable for all DEC_LATENCY+1 cycles of a round.
//           If lat_cnt!=DEC_LATENCY: lat_cnt++.
//           Else: state_reg<=dec_decrypted, lat_cnt<=0.
//             If round==0: plaintext<=dec_decrypted, go to DONE.
//             Otherwise: round--.
//   DONE:   out_valid=1, plaintext held stable; on out_ready go to IDLE.
//           out_valid stays high until accepted.
//  Latency: out_valid rises 1+NR*(DEC_LATENCY+1) edges after the accepting edge (21 at defaults).
//  Throughput: one block per 3+NR*(DEC_LATENCY+1) cycles at most. No overlap of blocks.
//  in_ready=0 in WHITEN/RUN/DONE; in_valid is ignored there and ciphertext is not sampled.
//  in_valid and out_ready may both be high in DONE: DONE->IDLE only. New input is
//   accepted on the next cycle, not the same one.
//  dec_last_round is 0 outside RUN. key_addr=0 in IDLE and DONE.
//  round counter is 4 bits and never wraps: it is decremented only while round>0.
//  dec_data = state_reg in all states (0 after reset).
// STRUCTURE
//  aes_pkg: AES_BLOCK_W=128, AES_NR=10, AES_KEY_IDX_W=4,
//   typedef enum logic [1:0] {IDLE, WHITEN, RUN, DONE} dec_ctrl_state_t.
//  Single module with no sub-modules. The latency counter and FSM are inline.
//  The round datapath is instantiated by the parent, not here.
// TESTING
//  Bench: real round datapath plus key store preloaded with expanded key 000102..0f.
//  1 FIPS-197 C.1: ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a
//    -> plaintext 00112233445566778899aabbccddeeff, out_valid 21 edges after accept.
//  2 key_addr trace: expect 10 (WHITEN), then 9,9,8,8,...,0,0.
//    dec_last_round high only in the two cycles with key_addr=0.
//  3 out_ready held 0 for 5 cycles after out_valid -> plaintext and out_valid stable.
//    Then out_ready=1 -> IDLE next edge, in_ready=1.
//  4 in_valid held high with ciphertext changed to all-ones during RUN
//    -> ignored, C.1 result unchanged.
//    Back-to-back blocks -> second accepted the cycle after DONE exits.
//  5 n_rst pulsed at round 5 -> all outputs at reset values immediately.
//    Next block completes correctly.
//  6 DEC_LATENCY=0 build: C.1 vector correct, out_valid 11 edges after accept.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES widths and decrypt-controller state encoding
package aes_pkg;

  localparam int AES_BLOCK_W   = 128;
  localparam int AES_NR        = 10;
  localparam int AES_KEY_IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WHITEN,
    RUN,
    DONE
  } dec_ctrl_state_t;

endpackage

// File: rtl/aes_dec_round_ctrl.sv
// rtl/aes_dec_round_ctrl.sv - iterative AES-128 inverse-cipher sequencer around an external round datapath
module aes_dec_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR          = AES_NR,
  parameter int DEC_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AES_BLOCK_W-1:0]   ciphertext,
  output logic [AES_KEY_IDX_W-1:0] key_addr,
  input  logic [AES_BLOCK_W-1:0]   key_data,
  output logic [AES_BLOCK_W-1:0]   dec_data,
  output logic [AES_BLOCK_W-1:0]   dec_round_key,
  output logic                     dec_last_round,
  input  logic [AES_BLOCK_W-1:0]   dec_decrypted,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [AES_BLOCK_W-1:0]   plaintext,
  output logic                     busy
);

  localparam int LAT_W = (DEC_LATENCY < 1) ? 1 : $clog2(DEC_LATENCY + 1);

  dec_ctrl_state_t          state_q;
  logic [AES_BLOCK_W-1:0]   state_reg_q;
  logic [AES_BLOCK_W-1:0]   plaintext_q;
  logic [AES_KEY_IDX_W-1:0] round_q;
  logic [LAT_W-1:0]         lat_cnt_q;

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_q     <= IDLE;
      state_reg_q <= '0;
      plaintext_q <= '0;
      round_q     <= '0;
      lat_cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_reg_q <= ciphertext;
            state_q     <= WHITEN;
          end
        end
        WHITEN: begin
          state_reg_q <= state_reg_q ^ key_data;
          round_q     <= AES_KEY_IDX_W'(NR - 1);
          lat_cnt_q   <= '0;
          state_q     <= RUN;
        end
        RUN: begin
          // Each round holds its drives for DEC_LATENCY+1 cycles, sampling on the last one.
          if (lat_cnt_q != LAT_W'(DEC_LATENCY)) begin
            lat_cnt_q <= lat_cnt_q + 1'b1;
          end else begin
            state_reg_q <= dec_decrypted;
            lat_cnt_q   <= '0;
            if (round_q == '0) begin
              plaintext_q <= dec_decrypted;
              state_q     <= DONE;
            end else begin
              round_q <= round_q - 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    key_addr = '0;
    if (state_q == WHITEN) begin
      key_addr = AES_KEY_IDX_W'(NR);
    end else if (state_q == RUN) begin
      key_addr = round_q;
    end
  end

  assign in_ready       = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign out_valid      = (state_q == DONE);
  assign dec_last_round = (state_q == RUN) && (round_q == '0);
  assign dec_data       = state_reg_q;
  assign dec_round_key  = key_data;
  assign plaintext      = plaintext_q;

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// tb/tb_aes_dec_round_ctrl.sv - directed bench with a behavioural inverse-round datapath and key store
module tb_aes_dec_round_ctrl;

  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT2 = 128'hdeadbeef0123456789abcdeffedcba98;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         in_valid, in_valid0;
  logic         in_ready, in_ready0;
  logic [127:0] ciphertext, ciphertext0;
  logic [3:0]   key_addr, key_addr0;
  logic [127:0] key_data, key_data0;
  logic [127:0] dec_data, dec_data0;
  logic [127:0] dec_round_key, dec_round_key0;
  logic         dec_last_round, dec_last_round0;
  logic [127:0] dec_decrypted, dec_decrypted0;
  logic         out_valid, out_valid0;
  logic         out_ready, out_ready0;
  logic [127:0] plaintext, plaintext0;
  logic         busy, busy0;

  logic [127:0] rk [0:10];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_dec_round_ctrl #(.NR(10), .DEC_LATENCY(1)) dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
    .ciphertext(ciphertext), .key_addr(key_addr), .key_data(key_data),
    .dec_data(dec_data), .dec_round_key(dec_round_key), .dec_last_round(dec_last_round),
    .dec_decrypted(dec_decrypted), .out_valid(out_valid), .out_ready(out_ready),
    .plaintext(plaintext), .busy(busy)
  );

  aes_dec_round_ctrl #(.NR(10), .DEC_LATENCY(0)) dut0 (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .ciphertext(ciphertext0), .key_addr(key_addr0), .key_data(key_data0),
    .dec_data(dec_data0), .dec_round_key(dec_round_key0), .dec_last_round(dec_last_round0),
    .dec_decrypted(dec_decrypted0), .out_valid(out_valid0), .out_ready(out_ready0),
    .plaintext(plaintext0), .busy(busy0)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, b, e;
    r = 8'h01;
    b = a;
    e = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, b);
      b = gmul(b, b);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] inv_round(input logic [127:0] d, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[r+4*c] = inv_sbox(d[127-8*(r+4*((c-r+4)%4)) -: 8]) ^ k[127-8*(r+4*c) -: 8];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
        t[4*c+1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
        t[4*c+2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
        t[4*c+3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o;
  endfunction

  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
    logic [127:0] s;
    s = ct ^ rk[10];
    for (int r = 9; r >= 0; r--) s = inv_round(s, rk[r], r == 0);
    return s;
  endfunction

  assign key_data  = (key_addr  <= 4'd10) ? rk[key_addr]  : '0;
  assign key_data0 = (key_addr0 <= 4'd10) ? rk[key_addr0] : '0;

  logic [127:0] dec_q;
  always_ff @(posedge clk) dec_q <= inv_round(dec_data, dec_round_key, dec_last_round);
  assign dec_decrypted = dec_q;
  always_comb dec_decrypted0 = inv_round(dec_data0, dec_round_key0, dec_last_round0);

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expand_key();
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [127:0] key;
    logic [7:0]   rc;
    key = 128'h000102030405060708090a0b0c0d0e0f;
    rc  = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox(tmp[31:24]) ^ rc, sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Entered #1 after the accepting edge; walks WHITEN and all 20 RUN cycles to DONE.
  task automatic run_rounds(input logic [127:0] pt);
    logic [3:0] exp_addr;
    logic       exp_last, exp_ov;
    check("whiten", {in_ready, busy, out_valid, dec_last_round, key_addr}, {4'b0100, 4'd10});
    ciphertext = '1;
    for (int j = 1; j <= 21; j++) begin
      @(posedge clk); #1;
      exp_addr = (j <= 20) ? 4'(9 - (j - 1) / 2) : 4'd0;
      exp_last = (j == 19) || (j == 20);
      exp_ov   = (j == 21);
      check($sformatf("trace%0d", j), {in_ready, busy, out_valid, dec_last_round, key_addr},
            {1'b0, 1'b1, exp_ov, exp_last, exp_addr});
    end
    check("plaintext", plaintext, pt);
  endtask

  initial begin
    int n;
    expand_key();
    n_rst = 1'b1;
    in_valid = 1'b0; ciphertext = '0; out_ready = 1'b0;
    in_valid0 = 1'b0; ciphertext0 = '0; out_ready0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctl", {in_ready, out_valid, busy, dec_last_round, key_addr}, 8'h80);
    check("rst_pt", plaintext, '0);
    check("rst_data", dec_data, '0);
    n_rst = 1'b0;
    @(posedge clk); #1;
    check("idle", {in_ready, busy, out_valid}, 3'b100);

    // C.1 vector; in_valid stays high with garbage data while the block runs
    in_valid = 1'b1; ciphertext = CT1;
    @(posedge clk); #1;
    run_rounds(PT1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("hold_ctl", {in_ready, busy, out_valid}, 3'b011);
      check("hold_pt", plaintext, PT1);
    end
    ciphertext = CT2; out_ready = 1'b1;
    @(posedge clk); #1;
    check("done_exit", {in_ready, busy, out_valid}, 3'b100);
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    run_rounds(ref_decrypt(CT2));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Asynchronous abort while key 5 is on the bus
    in_valid = 1'b1; ciphertext = CT1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("mid_addr", key_addr, 4'd5);
    #2 n_rst = 1'b1;
    #1;
    check("abort_ctl", {in_ready, out_valid, busy, dec_last_round, key_addr}, 8'h80);
    check("abort_pt", plaintext, '0);
    check("abort_data", dec_data, '0);
    @(posedge clk); #1;
    n_rst = 1'b0;
    @(posedge clk); #1;
    check("abort_idle", {in_ready, busy, out_valid}, 3'b100);
    in_valid = 1'b1; ciphertext = CT1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    run_rounds(PT1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Zero-latency datapath build
    check("l0_idle", {in_ready0, busy0, out_valid0}, 3'b100);
    in_valid0 = 1'b1; ciphertext0 = CT1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    n = 0;
    while (!out_valid0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("l0_latency", 128'(n), 128'd11);
    check("l0_pt", plaintext0, PT1);
    out_ready0 = 1'b1;
    @(posedge clk); #1;
    out_ready0 = 1'b0;
    check("l0_exit", {in_ready0, busy0, out_valid0}, 3'b100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
